// File: rtl/cpu_pkg.sv
// Shared decode types and helpers for the issue/hazard control path.
package cpu_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'd0;
  localparam logic [31:0] NOP      = 32'h0;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
  } sb_entry_t;

  // used[0] = rs read, used[1] = rt read
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] used;
    logic [4:0] dst;
  } decode_t;

  // Takes instr[31:11]: op, rs, rt, rd.
  function automatic decode_t decode(input logic [20:0] hdr);
    decode_t d;
    d.rs = hdr[14:10];
    d.rt = hdr[9:5];
    if (hdr[20:15] == OP_RTYPE) begin
      d.used = 2'b11;
      d.dst  = hdr[4:0];
    end else begin
      // I-type writes rt, matching the ID write-register mux
      d.used = 2'b01;
      d.dst  = hdr[9:5];
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations with source-match hazard detect.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_v,
  input  logic [4:0] push_dst,
  input  logic       clr,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       rt_used,
  output logic       hz
);

  sb_entry_t [DEPTH-1:0] slots_q, slots_d;

  always_comb begin
    slots_d    = '0;
    slots_d[0] = '{v: push_v & (push_dst != 5'd0), dst: push_dst};
    for (int unsigned i = 1; i < DEPTH; i++) begin
      slots_d[i] = slots_q[i-1];
    end
    if (clr) begin
      slots_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

  // r0 is never tracked, so a zero source can never match
  always_comb begin
    hz = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (slots_q[k].v && (slots_q[k].dst != 5'd0) &&
          ((slots_q[k].dst == rs) || (rt_used && (slots_q[k].dst == rt)))) begin
        hz = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue controller: holds instructions with RAW hazards, emits NOP bubbles, counts stalls.
module issue_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [31:0]      out_instr,
  output logic             out_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  decode_t          dec;
  logic             sb_hz;
  logic             hz;
  logic             issue;
  logic             stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign dec = decode(in_instr[31:11]);

  hazard_scoreboard #(
    .DEPTH(DEPTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_v  (issue),
    .push_dst(dec.dst),
    .clr     (flush),
    .rs      (dec.rs),
    .rt      (dec.rt),
    .rt_used (dec.used[1]),
    .hz      (sb_hz)
  );

  // rst_n in the issue term forces NOP output asynchronously while in reset
  assign hz    = in_valid & sb_hz;
  assign issue = in_valid & ~hz & ~flush & rst_n;
  assign stall = in_valid & hz & ~flush;

  assign in_ready   = issue;
  assign out_instr  = issue ? in_instr : NOP;
  assign out_bubble = ~issue;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule
